// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the pipelined RISC-V core.
//               Holds the datapath widths, the decoded-control bundle that
//               travels opaquely from decode to execute, and a small helper
//               used to compare register indices for hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Datapath and register-file geometry
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 16;
  localparam int CNT_W      = 16;

  // Decoded-control bundle. The operand-fetch stage never looks inside it;
  // it is latched and handed to execute as a flat CTRL_W-bit vector.
  typedef struct packed {
    logic [3:0] alu_op;       // ALU operation select
    logic [2:0] funct3;       // raw funct3 for branch/memory sizing
    logic       alu_src_imm;  // second ALU operand is the immediate
    logic       mem_read;     // memory read
    logic       mem_write;    // memory write
    logic       reg_write;    // instruction writes rd
    logic       branch;       // conditional branch
    logic       jump;         // JAL/JALR
    logic [2:0] rsvd;         // spare, keeps the bundle at CTRL_W bits
  } ctrl_t;

  // True when a consumer index depends on a producer index. Register x0 is
  // hard-wired to zero, so it can never create a dependency.
  function automatic logic reg_dep(input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass
// Description : Combinational priority mux resolving one source operand.
//               Priority: x0 -> zero, then the execute/memory result (only
//               when it is not a load, whose data is not ready yet), then the
//               writeback result, then the register bank read data.
// Ports       : rs                       - source register index
//               rf_rdata                 - register bank read data for rs
//               exm_valid/is_load/rd/data- execute/memory result
//               wb_en/wb_rd/wb_data      - writeback result
//               val                      - resolved operand value
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [XLEN-1:0]   rf_rdata,
  input  logic              exm_valid,
  input  logic              exm_is_load,
  input  logic [ADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   val
);

  logic w_rs_zero;
  logic w_hit_exm;
  logic w_hit_wb;

  // Checking rs first means a producer that targets x0 never forwards.
  assign w_rs_zero = (rs == '0);
  assign w_hit_exm = exm_valid && !exm_is_load && (exm_rd == rs);
  assign w_hit_wb  = wb_en && (wb_rd == rs);

  always_comb begin
    val = rf_rdata;
    if (w_rs_zero) begin
      val = '0;
    end else if (w_hit_exm) begin
      val = exm_data;
    end else if (w_hit_wb) begin
      // The bank only shows this write next cycle, so bypass it now.
      val = wb_data;
    end
  end

endmodule : operand_bypass
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Operand-fetch stage between decode and execute. Drives the
//               register bank read ports, resolves both source operands via
//               forwarding, stalls on load-use and on dependencies on the
//               instruction still held in ID/EX, and latches the resolved
//               instruction into the ID/EX register behind valid/ready.
// Ports       : clk, rst_n (async, active-low), flush
//               in_*      - decoded instruction from decode (valid/ready)
//               rf_*      - register bank asynchronous read ports
//               exm_*     - execute/memory result for forwarding
//               wb_*      - writeback result for forwarding
//               out_*     - ID/EX register contents (valid/ready)
//               stall_cnt - saturating count of hazard-stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter int CTRL_W = riscv_pkg::CTRL_W,
  parameter int CNT_W  = riscv_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  // decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  // register bank
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  // execute/memory result
  input  logic              exm_valid,
  input  logic [ADDR_W-1:0] exm_rd,
  input  logic              exm_is_load,
  input  logic [XLEN-1:0]   exm_data,
  // writeback result
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  // execute side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  import riscv_pkg::*;

  // --------------------------------------------------------------------------
  // ID/EX register and stall counter
  // --------------------------------------------------------------------------
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_pc;
  logic [XLEN-1:0]   r_out_imm;
  logic [XLEN-1:0]   r_out_rs1_val;
  logic [XLEN-1:0]   r_out_rs2_val;
  logic [ADDR_W-1:0] r_out_rd;
  logic              r_out_is_load;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_rs1_hazard;
  logic            w_rs2_hazard;
  logic            w_hazard;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_stall_inc;
  logic            w_cnt_sat;

  // Read addresses go straight to the bank; data comes back the same cycle.
  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  operand_bypass #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_bypass_rs1 (
    .rs          (in_rs1),
    .rf_rdata    (rf_rdata1),
    .exm_valid   (exm_valid),
    .exm_is_load (exm_is_load),
    .exm_rd      (exm_rd),
    .exm_data    (exm_data),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .val         (w_rs1_val)
  );

  operand_bypass #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_bypass_rs2 (
    .rs          (in_rs2),
    .rf_rdata    (rf_rdata2),
    .exm_valid   (exm_valid),
    .exm_is_load (exm_is_load),
    .exm_rd      (exm_rd),
    .exm_data    (exm_data),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .val         (w_rs2_val)
  );

  // Two dependencies cannot be forwarded:
  //  - a load in execute/memory whose data is not back yet (load-use);
  //  - the instruction still sitting in ID/EX, whose result does not exist
  //    until it has moved on to execute.
  // An operand the instruction does not read never stalls it.
  assign w_rs1_hazard = in_use_rs1 &&
                        ((exm_valid && exm_is_load && reg_dep(in_rs1, exm_rd)) ||
                         (r_out_valid && reg_dep(in_rs1, r_out_rd)));
  assign w_rs2_hazard = in_use_rs2 &&
                        ((exm_valid && exm_is_load && reg_dep(in_rs2, exm_rd)) ||
                         (r_out_valid && reg_dep(in_rs2, r_out_rd)));
  assign w_hazard     = in_valid && (w_rs1_hazard || w_rs2_hazard);

  // Ready needs the slot free (or being emptied this cycle) and nothing
  // blocking; a flush refuses the incoming instruction outright.
  assign w_in_ready  = !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_stall_inc = w_hazard && !flush;
  assign w_cnt_sat   = (r_stall_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_imm     <= '0;
      r_out_rs1_val <= '0;
      r_out_rs2_val <= '0;
      r_out_rd      <= '0;
      r_out_is_load <= 1'b0;
      r_out_ctrl    <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (flush) begin
        // Squash only clears valid; the stale payload is harmless.
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_pc      <= in_pc;
        r_out_imm     <= in_imm;
        r_out_rs1_val <= w_rs1_val;
        r_out_rs2_val <= w_rs2_val;
        r_out_rd      <= in_rd;
        r_out_is_load <= in_is_load;
        r_out_ctrl    <= in_ctrl;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_stall_inc && !w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_imm     = r_out_imm;
  assign out_rs1_val = r_out_rs1_val;
  assign out_rs2_val = r_out_rs2_val;
  assign out_rd      = r_out_rd;
  assign out_is_load = r_out_is_load;
  assign out_ctrl    = r_out_ctrl;
  assign stall_cnt   = r_stall_cnt;

endmodule : operand_fetch
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch. A behavioural model
//               of the ID/EX slot, the forwarding rules and the stall counter
//               runs alongside a directed vector table, hand-written hazard /
//               back-pressure / flush / reset sequences and random traffic.
//               A register-bank model answers the DUT read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_is_load;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        exm_valid;
  logic [4:0]  exm_rd;
  logic        exm_is_load;
  logic [31:0] exm_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_is_load;
  logic [15:0] out_ctrl;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_is_load(in_is_load), .in_ctrl(in_ctrl),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .exm_valid(exm_valid), .exm_rd(exm_rd), .exm_is_load(exm_is_load),
    .exm_data(exm_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_imm(out_imm), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_is_load(out_is_load), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  // Register bank: written on the clock edge, visible on the next cycle.
  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) if (wb_en && wb_rd != 5'd0) rf[wb_rd] <= wb_data;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_v;
  logic [31:0] m_pc, m_imm, m_rs1, m_rs2;
  logic [4:0]  m_rd;
  logic        m_load;
  logic [15:0] m_ctrl;
  int          m_cnt;

  task automatic model_reset();
    m_v = 0; m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0;
    m_rd = 0; m_load = 0; m_ctrl = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (exm_valid && !exm_is_load && exm_rd == rs) return exm_data;
    if (wb_en && wb_rd == rs) return wb_data;
    return rf[rs];
  endfunction

  function automatic logic blocked(input logic [4:0] rs, input logic used);
    if (!used || rs == 0) return 1'b0;
    return (exm_valid && exm_is_load && exm_rd == rs) || (m_v && m_rd == rs);
  endfunction

  // Called mid-cycle with inputs settled: checks combinational outputs,
  // advances the model across the next rising edge, then checks the state.
  task automatic advance();
    logic hz, rdy;
    logic [31:0] v1, v2;
    hz  = in_valid && (blocked(in_rs1, in_use_rs1) || blocked(in_rs2, in_use_rs2));
    rdy = !flush && !hz && (!m_v || out_ready);
    v1  = resolve(in_rs1);
    v2  = resolve(in_rs2);
    check("in_ready", in_ready, rdy);
    check("rf_raddr", {rf_raddr1, rf_raddr2}, {in_rs1, in_rs2});
    if (hz && !flush && m_cnt < 65535) m_cnt++;
    if (flush) m_v = 0;
    else if (in_valid && rdy) begin
      m_v = 1; m_pc = in_pc; m_imm = in_imm; m_rs1 = v1; m_rs2 = v2;
      m_rd = in_rd; m_load = in_is_load; m_ctrl = in_ctrl;
    end else if (out_ready) m_v = 0;
    @(posedge clk); #1;
    check("out_valid", out_valid, m_v);
    check("out_pc_imm", {out_pc, out_imm}, {m_pc, m_imm});
    check("out_ops", {out_rs1_val, out_rs2_val}, {m_rs1, m_rs2});
    check("out_rd_ld_ctrl", {out_rd, out_is_load, out_ctrl}, {m_rd, m_load, m_ctrl});
    check("stall_cnt", stall_cnt, 16'(m_cnt));
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic ctrl_t mk_ctrl(input logic [31:0] pc);
    ctrl_t c;
    c = '0;
    c.alu_op    = pc[7:4];
    c.funct3    = pc[10:8];
    c.reg_write = 1'b1;
    c.branch    = pc[11];
    return c;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2);
    in_valid = v; in_pc = pc; in_imm = pc ^ 32'h5A5A_0000;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_use_rs1 = u1; in_use_rs2 = u2; in_is_load = pc[4];
    in_ctrl = mk_ctrl(pc);
  endtask

  task automatic set_fwd(input logic ev, input logic el, input logic [4:0] erd,
                         input logic [31:0] ed, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wd);
    exm_valid = ev; exm_is_load = el; exm_rd = erd; exm_data = ed;
    wb_en = we; wb_rd = wrd; wb_data = wd;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic        ev, el;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] x1, x2;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic ev,
                              input logic el, input logic [4:0] erd,
                              input logic [31:0] ed, input logic we,
                              input logic [4:0] wrd, input logic [31:0] wd,
                              input logic rdy, input logic [31:0] x1,
                              input logic [31:0] x2);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ev = ev; v.el = el;
    v.erd = erd; v.ed = ed; v.we = we; v.wrd = wrd; v.wd = wd;
    v.rdy = rdy; v.x1 = x1; v.x2 = x2;
    return v;
  endfunction

  vec_t tbl [10];
  int   base;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 0; rf[3] = 32'h11; rf[4] = 32'h22; rf[5] = 32'hCCCC;
    rf[6] = 32'h66; rf[7] = 32'h77;

    //          rs1 rs2 u1 u2 ev el erd ed            we wrd wd            rdy x1            x2
    tbl[0] = mk(3,  4,  1, 1, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1,  32'h11,       32'h22);
    tbl[1] = mk(5,  4,  1, 1, 1, 0, 5,  32'hAAAA,     1, 5,  32'hBBBB,     1,  32'hAAAA,     32'h22);
    tbl[2] = mk(5,  3,  1, 1, 0, 0, 5,  32'hAAAA,     1, 5,  32'hBBBC,     1,  32'hBBBC,     32'h11);
    tbl[3] = mk(5,  5,  1, 1, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1,  32'hBBBC,     32'hBBBC);
    tbl[4] = mk(0,  0,  1, 1, 1, 0, 0,  32'hDEAD,     1, 0,  32'hBEEF,     1,  32'h0,        32'h0);
    tbl[5] = mk(6,  0,  0, 1, 1, 1, 6,  32'h6666,     0, 0,  32'h0,        1,  32'h66,       32'h0);
    tbl[6] = mk(3,  4,  1, 1, 1, 0, 3,  32'h3333,     1, 4,  32'h4444,     1,  32'h3333,     32'h4444);
    tbl[7] = mk(7,  4,  1, 1, 0, 0, 7,  32'h9999,     0, 0,  32'h0,        1,  32'h77,       32'h4444);
    tbl[8] = mk(1,  7,  1, 1, 1, 1, 7,  32'h0,        0, 0,  32'h0,        0,  32'h0,        32'h0);
    tbl[9] = mk(1,  7,  1, 0, 1, 1, 7,  32'h7E7E,     0, 0,  32'h0,        1,  32'h1001,     32'h77);

    // ---- reset state ----
    rst_n = 0; flush = 0; out_ready = 1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_valid_cnt", {out_valid, stall_cnt}, 17'd0);
    check("reset_payload", {out_pc, out_rs1_val, out_rs2_val, out_ctrl}, 112'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // ---- directed table, back-to-back accepts ----
    for (int i = 0; i < 10; i++) begin
      set_in(1, 32'h100 + 32'(i) * 4, tbl[i].rs1, tbl[i].rs2, 5'd0, tbl[i].u1, tbl[i].u2);
      set_fwd(tbl[i].ev, tbl[i].el, tbl[i].erd, tbl[i].ed, tbl[i].we, tbl[i].wrd, tbl[i].wd);
      #4;
      check($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
      advance();
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].rdy);
      if (tbl[i].rdy)
        check($sformatf("tbl%0d_ops", i), {out_rs1_val, out_rs2_val}, {tbl[i].x1, tbl[i].x2});
    end
    check("tbl_stall_cnt", stall_cnt, 16'd1);

    // ---- load-use: one stall, then wb forwarding ----
    base = m_cnt;
    set_in(1, 32'h500, 0, 7, 8, 0, 1);
    set_fwd(1, 1, 7, 32'hDEAD, 0, 0, 0);
    #4; check("lu_stall_ready", in_ready, 1'b0);
    advance();
    check("lu_stall_cnt", stall_cnt, 16'(base + 1));
    set_fwd(0, 0, 0, 0, 1, 7, 32'h7777);
    #4; check("lu_go_ready", in_ready, 1'b1);
    advance();
    check("lu_rs2_wb", {out_valid, out_pc, out_rs2_val}, {1'b1, 32'h500, 32'h7777});

    // ---- back-pressure: 3 cycles held, no stall counted ----
    base = m_cnt;
    set_in(1, 32'h600, 1, 2, 9, 1, 1);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #4; check("bp_ready", in_ready, 1'b0);
      advance();
      check("bp_hold", {out_valid, out_pc, out_rs2_val}, {1'b1, 32'h500, 32'h7777});
    end
    check("bp_stall_cnt", stall_cnt, 16'(base));
    out_ready = 1;
    #4; advance();
    check("bp_release", {out_valid, out_pc}, {1'b1, 32'h600});

    // ---- dependency on held instruction, resolved by exm forwarding ----
    base = m_cnt;
    set_in(1, 32'h700, 9, 0, 8, 1, 1);
    out_ready = 0;
    #4; check("dep_held_ready", in_ready, 1'b0);
    advance();
    out_ready = 1;
    #4; check("dep_leaving_ready", in_ready, 1'b0);
    advance();
    check("dep_stall_cnt", stall_cnt, 16'(base + 2));
    set_fwd(1, 0, 9, 32'h9999, 0, 0, 0);
    #4; advance();
    check("dep_exm_fwd", {out_valid, out_pc, out_rs1_val}, {1'b1, 32'h700, 32'h9999});

    // ---- flush while holding, with a would-be hazard ----
    base = m_cnt;
    set_in(1, 32'h800, 8, 2, 0, 1, 1);
    set_fwd(0, 0, 0, 0, 0, 0, 0);
    out_ready = 0; flush = 1;
    #4; check("flush_ready", in_ready, 1'b0);
    advance();
    check("flush_drop", {out_valid, out_pc}, {1'b0, 32'h700});
    check("flush_no_stall", stall_cnt, 16'(base));
    flush = 0;

    // ---- reset mid-stream ----
    set_in(1, 32'h900, 1, 2, 0, 1, 1);
    #4; advance();
    set_in(0, 0, 0, 0, 0, 0, 0);
    check("pre_reset_valid", out_valid, 1'b1);
    #1; rst_n = 0;
    #1;
    check("async_reset", {out_valid, stall_cnt, out_pc}, 49'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    set_in(1, 32'hA00, 3, 4, 2, 1, 1);
    #4; advance();
    check("post_reset_accept", {out_valid, out_pc, out_rs1_val, out_rs2_val},
          {1'b1, 32'hA00, 32'h11, 32'h4444});

    // ---- random traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(3) != 0), $urandom, 5'($urandom_range(7)),
             5'($urandom_range(7)), 5'($urandom_range(7)),
             1'($urandom), 1'($urandom));
      in_ctrl = 16'($urandom);
      set_fwd(1'($urandom), ($urandom_range(2) == 0), 5'($urandom_range(7)), $urandom,
              1'($urandom), 5'($urandom_range(7)), $urandom);
      flush = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(3) != 0);
      #4; advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_operand_fetch
`default_nettype wire

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage of the pipelined RISC-V core, placed between decode and execute. It drives the register bank's two asynchronous read ports and resolves each source operand from the register file, the execute/memory result or the writeback result. It stalls on hazards it cannot forward and latches the resolved instruction into the ID/EX pipeline register behind a valid/ready handshake.

## Interface
- XLEN, 32, data width
- ADDR_W, 5, register address width
- CTRL_W, 16, width of opaque decoded-control bundle passed through
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  squash the held instruction (branch redirect)
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc, in_imm  in  XLEN  PC, immediate
- in_rs1, in_rs2, in_rd  in  ADDR_W  register indices
- in_use_rs1, in_use_rs2  in  1  operand actually read
- in_is_load  in  1  instruction is a load
- in_ctrl  in  CTRL_W  control bundle
- rf_raddr1, rf_raddr2  out  ADDR_W  register bank read addresses
- rf_rdata1, rf_rdata2  in  XLEN  register bank read data
- exm_valid  in  1  execute/memory result valid
- exm_rd  in  ADDR_W  its destination
- exm_is_load  in  1  result is a load; data not yet available
- exm_data  in  XLEN  result value
- wb_en  in  1  writeback this cycle (same signal as the register bank write enable)
- wb_rd  in  ADDR_W  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute consumes it
- out_pc, out_imm, out_rs1_val, out_rs2_val  out  XLEN  latched PC, immediate and resolved operands
- out_rd  out  ADDR_W  latched destination
- out_is_load  out  1  latched load flag
- out_ctrl  out  CTRL_W  latched control
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- rf_raddr1/2 = in_rs1/in_rs2, driven combinationally at all times.
- Operand resolution, per operand, in priority order:
  - Index 0 gives 0.
  - Else, if exm_valid && !exm_is_load && exm_rd == rs, the operand is exm_data.
  - Else, if wb_en && wb_rd == rs, the operand is wb_data.
  - Else the operand is rf_rdata.
- A match on rd == 0 never forwards.
- hazard is raised when in_valid and either used operand (use bit set, index != 0) matches one of:
  - exm_rd, while exm_valid && exm_is_load (load-use);
  - out_rd, while out_valid (producer not yet in execute, so it cannot be forwarded).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready):
  - ID/EX register loads all in_* fields and the resolved operands.
  - out_valid <= 1.
- Else, if out_ready: out_valid <= 0. Payload registers hold their value.
- flush has priority over everything else: out_valid <= 0 and nothing is accepted that cycle.
- stall_cnt increments on each cycle with in_valid && hazard && !flush, and saturates at all-ones.
- Unused operands never cause a stall. Their value is don't-care but deterministic (the mux result).

## Timing
- Reset (asynchronous, rst_n low): out_valid = 0, every out_* payload = 0, stall_cnt = 0.
- Accepted instruction appears on out_* one cycle after the accepting edge; latency 1, throughput 1 per cycle with no hazard.
- The register bank writes on the clock edge, and the new value is readable from rf_rdata only on the next cycle. A same-cycle wb write therefore reaches the captured operand only through the wb bypass.
- Simultaneous accept and consume: out_valid stays 1 and the payload is replaced.
- Stall on the out_rd match lasts while out_valid. Once the producer moves to execute, exm forwarding resolves the dependency (load adds one more stall cycle).
- Reset mid-operation drops the held instruction; no partial state survives.

## Structure
- Shared package riscv_pkg: XLEN, REG_ADDR_W, CTRL_W constants, and the decoded-control struct typedef carried on in_ctrl/out_ctrl.
- One natural sub-module: operand_bypass. It is a combinational priority mux (zero / exm / wb / rf) and is instantiated twice. Hazard logic, the pipeline register and the counter stay in the top module.

## Test plan
- No hazard: in rs1=3, rs2=4 with rf x3=0x11, x4=0x22 and out_ready=1 -> out_rs1_val=0x11, out_rs2_val=0x22 next cycle. Back-to-back accepts every cycle.
- Bypass priority: rs1=5 with exm (rd=5, 0xAAAA), wb (rd=5, 0xBBBB) and rf 0xCCCC -> 0xAAAA. Drop exm -> 0xBBBB. rs1=0 with exm_rd=0 -> 0.
- Load-use: exm_valid, exm_is_load, exm_rd=7; instruction uses rs2=7 -> in_ready=0 for one cycle and stall_cnt=1. Next cycle accepted with the wb-forwarded value.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_* stable. stall_cnt unchanged, since that is not a hazard.
- Flush: flush during accept with out_valid=1 -> out_valid=0 next cycle and the input is not accepted.
- Reset mid-stream: rst_n low asynchronously with out_valid=1 -> out_valid and stall_cnt read 0 immediately. After release, the first accepted instruction proceeds normally.
